// File: rtl/mux_pipe_reg.sv
// N-way WIDTH-bit selector feeding a DEPTH-stage register pipeline. Each stage carries
// {data, valid, err}. Priority on every edge: reset, then flush, then stall, then shift.
module mux_pipe_reg #(
    parameter int              WIDTH   = 32,
    parameter int              N_IN    = 4,
    parameter int              SEL_W   = 2,
    parameter int              DEPTH   = 1,
    parameter logic [WIDTH-1:0] DEFAULT = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN*WIDTH-1:0] in_bus,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    output logic [WIDTH-1:0]      out,
    output logic                  out_valid,
    output logic                  out_err
);

    logic [WIDTH-1:0] d0;
    logic             e0;

    // Out-of-range selects fall through to DEFAULT with the error flag raised.
    always_comb begin
        d0 = DEFAULT;
        e0 = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel) == 32'(k)) begin
                d0 = in_bus[k*WIDTH +: WIDTH];
                e0 = 1'b0;
            end
        end
    end

    // Index 0 is stage 1; index DEPTH-1 drives the outputs.
    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0]            err_q, err_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        err_d   = err_q;
        if (flush) begin
            data_d  = '0;
            valid_d = '0;
            err_d   = '0;
        end else if (!stall) begin
            data_d[0]  = d0;
            valid_d[0] = in_valid;
            err_d[0]   = e0;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
                err_d[i]   = err_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= '0;
            err_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign out       = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign out_err   = err_q[DEPTH-1];

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Bench for mux_pipe_reg: two instances (4-input depth 2, 3-input depth 3 with a
// non-zero DEFAULT) share stimulus; a queue model checks every edge.
module tb_mux_pipe_reg;

    localparam int          DA    = 2;
    localparam int          DB    = 3;
    localparam int          NB    = 3;
    localparam logic [31:0] DEF_B = 32'hDEADBEEF;
    localparam logic [31:0] W0 = 32'h11111111, W1 = 32'h22222222,
                            W2 = 32'h33333333, W3 = 32'h44444444;

    logic         clk = 1'b0;
    logic         reset, in_valid, stall, flush;
    logic [127:0] in_bus;
    logic [1:0]   sel;
    logic [31:0]  out_a, out_b;
    logic         ova, oea, ovb, oeb;

    always #5 clk = ~clk;

    mux_pipe_reg #(.WIDTH(32), .N_IN(4), .SEL_W(2), .DEPTH(DA), .DEFAULT(32'h0)) dut_a (
        .clk(clk), .reset(reset), .in_bus(in_bus), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out_a), .out_valid(ova), .out_err(oea));

    mux_pipe_reg #(.WIDTH(32), .N_IN(NB), .SEL_W(2), .DEPTH(DB), .DEFAULT(DEF_B)) dut_b (
        .clk(clk), .reset(reset), .in_bus(in_bus[95:0]), .sel(sel), .in_valid(in_valid),
        .stall(stall), .flush(flush), .out(out_b), .out_valid(ovb), .out_err(oeb));

    typedef struct packed {
        logic [31:0] d;
        logic        v;
        logic        e;
    } rec_t;

    rec_t qa[$], qb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rec_t pick(input int n, input logic [31:0] dflt);
        rec_t r;
        r.v = in_valid;
        if (int'(sel) < n) begin
            r.d = in_bus[int'(sel)*32 +: 32];
            r.e = 1'b0;
        end else begin
            r.d = dflt;
            r.e = 1'b1;
        end
        return r;
    endfunction

    // One clock edge: advance the model from the pre-edge inputs, then compare both DUTs.
    task automatic tick();
        rec_t ra, rb;
        logic clr, hold;
        ra   = pick(4, 32'h0);
        rb   = pick(NB, DEF_B);
        clr  = reset || flush;
        hold = stall;
        @(posedge clk);
        if (clr) begin
            foreach (qa[i]) qa[i] = '0;
            foreach (qb[i]) qb[i] = '0;
        end else if (!hold) begin
            qa.push_front(ra);
            void'(qa.pop_back());
            qb.push_front(rb);
            void'(qb.pop_back());
        end
        #1;
        check("a_out",   out_a, qa[DA-1].d);
        check("a_valid", 32'(ova), 32'(qa[DA-1].v));
        check("a_err",   32'(oea), 32'(qa[DA-1].e));
        check("b_out",   out_b, qb[DB-1].d);
        check("b_valid", 32'(ovb), 32'(qb[DB-1].v));
        check("b_err",   32'(oeb), 32'(qb[DB-1].e));
    endtask

    typedef struct {
        logic        rst, v, stl, fl;
        logic [1:0]  s;
        logic [31:0] eo;
        logic        ev;
    } vec_t;

    function automatic vec_t mk(input logic rst, input logic v, input logic stl, input logic fl,
                                input logic [1:0] s, input logic [31:0] eo, input logic ev);
        vec_t t;
        t.rst = rst; t.v = v; t.stl = stl; t.fl = fl; t.s = s; t.eo = eo; t.ev = ev;
        return t;
    endfunction

    vec_t tbl[19];

    initial begin
        // Expected dut_a outputs (depth 2) after each row's edge.
        tbl[0]  = mk(1, 1, 0, 0, 0, 0,  0);
        tbl[1]  = mk(1, 1, 0, 0, 1, 0,  0);
        tbl[2]  = mk(1, 1, 0, 0, 2, 0,  0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0,  0);
        tbl[4]  = mk(0, 1, 0, 0, 1, W0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 2, W1, 1);
        tbl[6]  = mk(0, 1, 0, 0, 3, W2, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, W3, 1);
        tbl[8]  = mk(0, 0, 0, 0, 3, W0, 0);
        tbl[9]  = mk(0, 1, 0, 0, 2, W3, 0);
        tbl[10] = mk(0, 1, 0, 0, 1, W2, 1);
        tbl[11] = mk(0, 1, 1, 0, 3, W2, 1);
        tbl[12] = mk(0, 1, 1, 0, 3, W2, 1);
        tbl[13] = mk(0, 1, 1, 1, 3, 0,  0);
        tbl[14] = mk(0, 1, 0, 0, 0, 0,  0);
        tbl[15] = mk(0, 1, 0, 0, 1, W0, 1);
        tbl[16] = mk(1, 1, 0, 0, 2, 0,  0);
        tbl[17] = mk(0, 1, 0, 0, 3, 0,  0);
        tbl[18] = mk(0, 1, 0, 0, 0, W3, 1);

        for (int i = 0; i < DA; i++) qa.push_back('0);
        for (int i = 0; i < DB; i++) qb.push_back('0);
        reset = 1'b1; in_valid = 1'b1; stall = 1'b0; flush = 1'b0; sel = 2'd0;
        in_bus = {W3, W2, W1, W0};

        // Reset, select sweep, data-not-masked, stall, flush-with-stall, reset pulse.
        for (int i = 0; i < 19; i++) begin
            reset = tbl[i].rst; in_valid = tbl[i].v; stall = tbl[i].stl;
            flush = tbl[i].fl;  sel = tbl[i].s;
            tick();
            check($sformatf("tbl%0d_out", i),   out_a, tbl[i].eo);
            check($sformatf("tbl%0d_valid", i), 32'(ova), 32'(tbl[i].ev));
            check($sformatf("tbl%0d_err", i),   32'(oea), 32'h0);
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0;

        // Out-of-range select on the 3-input, depth-3 instance.
        in_valid = 1'b1; sel = 2'd3; tick();
        sel = 2'd0; tick(); tick();
        check("oor_out",   out_b, DEF_B);
        check("oor_valid", 32'(ovb), 32'h1);
        check("oor_err",   32'(oeb), 32'h1);
        tick();
        check("oor_next_out", out_b, W0);
        check("oor_next_err", 32'(oeb), 32'h0);

        // Stall for three edges after B is sampled; X is only offered during the stall.
        in_bus = {32'h99, 32'hC, 32'hB, 32'hA};
        sel = 2'd0; tick();
        sel = 2'd1; tick();
        check("stall_a0", out_a, 32'hA);
        stall = 1'b1; sel = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall_hold%0d", i), out_a, 32'hA);
            check($sformatf("stall_hv%0d", i), 32'(ova), 32'h1);
        end
        stall = 1'b0; sel = 2'd2; tick();
        check("stall_b", out_a, 32'hB);
        sel = 2'd0; in_valid = 1'b0; tick();
        check("stall_c", out_a, 32'hC);
        check("stall_cv", 32'(ova), 32'h1);
        tick();
        check("stall_end_v", 32'(ova), 32'h0);

        // Continuous stream, then a one-cycle reset pulse.
        in_bus = {32'h0D0D0D0D, 32'h0C0C0C0C, 32'h0B0B0B0B, 32'h0A0A0A0A};
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sel = 2'(i); tick();
        end
        reset = 1'b1; sel = 2'd3; tick();
        check("mrst_out", out_a, 32'h0);
        check("mrst_v",   32'(ova), 32'h0);
        reset = 1'b0; sel = 2'd1; tick();
        check("mrst_gap_v", 32'(ova), 32'h0);
        check("mrst_gap_d", out_a, 32'h0);
        sel = 2'd2; tick();
        check("mrst_first", out_a, 32'h0B0B0B0B);
        check("mrst_first_v", 32'(ova), 32'h1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            in_bus   = {$urandom, $urandom, $urandom, $urandom};
            sel      = 2'($urandom_range(0, 3));
            in_valid = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 99) < 20);
            flush    = ($urandom_range(0, 99) < 5);
            reset    = ($urandom_range(0, 99) < 3);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
